// File: rtl/pu_tag_req_arb_pkg.sv
// Shared types and system constants for the tag-lookup request front end.
package pu_tag_req_arb_pkg;

   localparam int NUM_OF_PU                = 8;
   localparam int PU_WIDTH_NBITS           = 32;
   localparam int TAG_NBITS                = 12;
   localparam int PU_ID_NBITS              = 5;
   localparam int PU_ADDR_NBITS            = 16;
   localparam int PU_MEM_DEPTH_MSB         = 15;
   localparam int PU_MEM_DEPTH_LSB         = 12;
   localparam logic [3:0] PU_TAG_LOOKUP_REQ = 4'hC;
   localparam int TAG_REQ_MAX_OUTSTANDING  = 4;
   localparam int TAG_REQ_FIFO_DEPTH_NBITS = 2;

   typedef struct packed {
      logic                      wr;
      logic [PU_ADDR_NBITS-1:0]  addr;
      logic [PU_WIDTH_NBITS-1:0] wdata;
   } io_type;

   // A PU command targets the tag-lookup request window when it is a write
   // whose upper address bits select the lookup register.
   function automatic logic is_tag_req(input io_type cmd);
      return cmd.wr && (cmd.addr[PU_MEM_DEPTH_MSB:PU_MEM_DEPTH_LSB] == PU_TAG_LOOKUP_REQ);
   endfunction

endpackage

// File: rtl/pu_tag_req_arb_fifo.sv
// Per-PU key FIFO, first-word fall-through. Write on full is only legal
// when the same cycle also pops; the caller guarantees that.
module pu_tag_key_fifo #(
   parameter int KEY_NBITS   = 12,
   parameter int DEPTH_NBITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_i,
   input  logic [KEY_NBITS-1:0] din_i,
   input  logic                 rd_i,
   output logic [KEY_NBITS-1:0] dout_o,
   output logic                 full_o,
   output logic                 empty_o
);

   localparam int DEPTH = 1 << DEPTH_NBITS;

   logic [KEY_NBITS-1:0] mem_q [DEPTH];
   logic [DEPTH_NBITS:0] wr_ptr_q, rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[DEPTH_NBITS] != rd_ptr_q[DEPTH_NBITS]) &&
                    (wr_ptr_q[DEPTH_NBITS-1:0] == rd_ptr_q[DEPTH_NBITS-1:0]);
   assign dout_o  = mem_q[rd_ptr_q[DEPTH_NBITS-1:0]];

   // Storage array; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (wr_i) mem_q[wr_ptr_q[DEPTH_NBITS-1:0]] <= din_i;
   end

   // Read/write pointers with an extra wrap bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (wr_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/pu_tag_req_arb.sv
// Tag-lookup request front end: per-PU key FIFOs, round-robin issue with a
// minimum inter-issue gap and a credit limit on outstanding lookups.
module pu_tag_req_arb
   import pu_tag_req_arb_pkg::*;
#(
   parameter int NUM_OF_PU        = pu_tag_req_arb_pkg::NUM_OF_PU,
   parameter int WIDTH_NBITS      = PU_WIDTH_NBITS,
   parameter int KEY_NBITS        = TAG_NBITS,
   parameter int FIFO_DEPTH_NBITS = TAG_REQ_FIFO_DEPTH_NBITS,
   parameter int MAX_OUTSTANDING  = TAG_REQ_MAX_OUTSTANDING,
   parameter int GAP_NBITS        = 3
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [GAP_NBITS-1:0]                   cfg_issue_gap_i,
   input  logic                                   err_clr_i,
   input  logic [NUM_OF_PU-1:0]                   io_req_i,
   input  io_type [NUM_OF_PU-1:0]                 io_cmd_i,
   output logic [NUM_OF_PU-1:0]                   io_ack_o,
   output logic [NUM_OF_PU-1:0][WIDTH_NBITS-1:0]  io_ack_data_o,
   output logic                                   tag_key_valid_o,
   output logic [KEY_NBITS-1:0]                   tag_key_o,
   output logic [PU_ID_NBITS-1:0]                 tag_pid_o,
   input  logic                                   tag_lookup_status_valid_i,
   output logic [3:0]                             outstanding_o,
   output logic [NUM_OF_PU-1:0]                   fifo_full_o,
   output logic [NUM_OF_PU-1:0]                   overflow_err_o,
   output logic                                   underflow_err_o
);

   logic [NUM_OF_PU-1:0] enq, fifo_wr, fifo_rd, fifo_full, fifo_empty, ovf_new;
   logic [KEY_NBITS-1:0] fifo_dout [NUM_OF_PU];

   logic [PU_ID_NBITS-1:0] rr_ptr_q, rr_ptr_d, sel;
   logic [GAP_NBITS-1:0]   gap_cnt_q, gap_cnt_d;
   logic [3:0]             outstanding_q, outstanding_d;
   logic                   eligible, grant, credit_ret, unf_new;

   logic                   tag_key_valid_q;
   logic [KEY_NBITS-1:0]   tag_key_q, tag_key_d;
   logic [PU_ID_NBITS-1:0] tag_pid_q, tag_pid_d;
   logic [NUM_OF_PU-1:0]   io_ack_q, overflow_q, overflow_d;
   logic                   underflow_q, underflow_d;

   // Only the key slice and decode bits of each command are consumed.
   logic unused_cmd_bits;
   assign unused_cmd_bits = ^io_cmd_i;

   for (genvar i = 0; i < NUM_OF_PU; i++) begin : g_pu
      assign enq[i] = io_req_i[i] & is_tag_req(io_cmd_i[i]);

      pu_tag_key_fifo #(
         .KEY_NBITS   (KEY_NBITS),
         .DEPTH_NBITS (FIFO_DEPTH_NBITS)
      ) u_fifo (
         .clk     (clk),
         .rst_n   (rst_n),
         .wr_i    (fifo_wr[i]),
         .din_i   (io_cmd_i[i].wdata[KEY_NBITS-1:0]),
         .rd_i    (fifo_rd[i]),
         .dout_o  (fifo_dout[i]),
         .full_o  (fifo_full[i]),
         .empty_o (fifo_empty[i])
      );
   end

   // A full FIFO still accepts a write when the arbiter pops it this cycle.
   assign fifo_wr = enq & (~fifo_full | fifo_rd);
   assign ovf_new = enq & fifo_full & ~fifo_rd;

   assign eligible = (|(~fifo_empty)) && (gap_cnt_q == '0) &&
                     (outstanding_q < 4'(MAX_OUTSTANDING));

   // Round-robin pick: first non-empty FIFO after the last granted PU.
   always_comb begin
      int idx;
      idx   = 0;
      grant = 1'b0;
      sel   = '0;
      if (eligible) begin
         for (int k = 1; k <= NUM_OF_PU; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_OF_PU) idx = idx - NUM_OF_PU;
            if (!grant && !fifo_empty[idx]) begin
               grant = 1'b1;
               sel   = PU_ID_NBITS'(idx);
            end
         end
      end
   end

   assign fifo_rd = grant ? (NUM_OF_PU'(1) << sel) : '0;

   // Next-state for pointer, gap timer, credits, issue registers and errors.
   always_comb begin
      rr_ptr_d  = grant ? sel : rr_ptr_q;
      gap_cnt_d = grant ? cfg_issue_gap_i :
                  (gap_cnt_q != '0) ? gap_cnt_q - 1'b1 : gap_cnt_q;

      credit_ret    = tag_lookup_status_valid_i && (outstanding_q != 4'd0);
      unf_new       = tag_lookup_status_valid_i && (outstanding_q == 4'd0);
      outstanding_d = outstanding_q;
      if (grant && !credit_ret)      outstanding_d = outstanding_q + 4'd1;
      else if (!grant && credit_ret) outstanding_d = outstanding_q - 4'd1;

      tag_key_d = grant ? fifo_dout[sel] : tag_key_q;
      tag_pid_d = grant ? sel : tag_pid_q;

      // A new error in the clearing cycle survives the clear.
      overflow_d  = (overflow_q & ~{NUM_OF_PU{err_clr_i}}) | ovf_new;
      underflow_d = (underflow_q & ~err_clr_i) | unf_new;
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q        <= PU_ID_NBITS'(NUM_OF_PU - 1);
         gap_cnt_q       <= '0;
         outstanding_q   <= '0;
         tag_key_valid_q <= 1'b0;
         tag_key_q       <= '0;
         tag_pid_q       <= '0;
         io_ack_q        <= '0;
         overflow_q      <= '0;
         underflow_q     <= 1'b0;
      end else begin
         rr_ptr_q        <= rr_ptr_d;
         gap_cnt_q       <= gap_cnt_d;
         outstanding_q   <= outstanding_d;
         tag_key_valid_q <= grant;
         tag_key_q       <= tag_key_d;
         tag_pid_q       <= tag_pid_d;
         io_ack_q        <= fifo_rd;
         overflow_q      <= overflow_d;
         underflow_q     <= underflow_d;
      end
   end

   assign io_ack_o        = io_ack_q;
   assign io_ack_data_o   = '0;
   assign tag_key_valid_o = tag_key_valid_q;
   assign tag_key_o       = tag_key_q;
   assign tag_pid_o       = tag_pid_q;
   assign outstanding_o   = outstanding_q;
   assign fifo_full_o     = fifo_full;
   assign overflow_err_o  = overflow_q;
   assign underflow_err_o = underflow_q;

endmodule

// File: tb/tb_pu_tag_req_arb.sv
// Directed scoreboard bench for pu_tag_req_arb.
module tb_pu_tag_req_arb;
   import pu_tag_req_arb_pkg::*;

   localparam int NPU = 8;

   logic                            clk = 1'b0;
   logic                            rst_n;
   logic [2:0]                      cfg_issue_gap;
   logic                            err_clr;
   logic [NPU-1:0]                  io_req;
   io_type [NPU-1:0]                io_cmd;
   logic [NPU-1:0]                  io_ack;
   logic [NPU-1:0][PU_WIDTH_NBITS-1:0] io_ack_data;
   logic                            tag_key_valid;
   logic [TAG_NBITS-1:0]            tag_key;
   logic [PU_ID_NBITS-1:0]          tag_pid;
   logic                            status_valid;
   logic [3:0]                      outstanding;
   logic [NPU-1:0]                  fifo_full;
   logic [NPU-1:0]                  overflow_err;
   logic                            underflow_err;

   pu_tag_req_arb #(
      .NUM_OF_PU        (NPU),
      .WIDTH_NBITS      (PU_WIDTH_NBITS),
      .KEY_NBITS        (TAG_NBITS),
      .FIFO_DEPTH_NBITS (2),
      .MAX_OUTSTANDING  (4),
      .GAP_NBITS        (3)
   ) dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .cfg_issue_gap_i           (cfg_issue_gap),
      .err_clr_i                 (err_clr),
      .io_req_i                  (io_req),
      .io_cmd_i                  (io_cmd),
      .io_ack_o                  (io_ack),
      .io_ack_data_o             (io_ack_data),
      .tag_key_valid_o           (tag_key_valid),
      .tag_key_o                 (tag_key),
      .tag_pid_o                 (tag_pid),
      .tag_lookup_status_valid_i (status_valid),
      .outstanding_o             (outstanding),
      .fifo_full_o               (fifo_full),
      .overflow_err_o            (overflow_err),
      .underflow_err_o           (underflow_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   pid;
      logic [TAG_NBITS-1:0] key;
   } exp_t;

   exp_t exp_q[$];
   int   issue_cyc[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   n_issue = 0;
   int   cyc = 0;
   int   base;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: every issue pops the oldest expected key and checks pid/key/ack.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && tag_key_valid) begin
         n_issue++;
         issue_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_issue: got pid %0d key 0x%0h, expected none", tag_pid, tag_key);
         end else begin
            e = exp_q.pop_front();
            check("issue_pid", 32'(tag_pid), 32'(e.pid));
            check("issue_key", 32'(tag_key), 32'(e.key));
            check("issue_ack", 32'(io_ack), 32'(1) << e.pid);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(input int pu, input logic [TAG_NBITS-1:0] key);
      io_req[pu]       = 1'b1;
      io_cmd[pu].wr    = 1'b1;
      io_cmd[pu].addr  = 16'hC000;
      io_cmd[pu].wdata = 32'(key);
   endtask

   task automatic clr_req();
      io_req = '0;
      io_cmd = '0;
   endtask

   task automatic expect_issue(input int pid, input logic [TAG_NBITS-1:0] key);
      exp_t e;
      e.pid = pid;
      e.key = key;
      exp_q.push_back(e);
   endtask

   task automatic complete();
      status_valid = 1'b1;
      tick();
      status_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cfg_issue_gap = '0; err_clr = 1'b0; status_valid = 1'b0;
      clr_req();
      tick(2);
      check("rst_valid", 32'(tag_key_valid), 0);
      check("rst_outstanding", 32'(outstanding), 0);
      check("rst_ack", 32'(io_ack), 0);
      check("rst_full", 32'(fifo_full), 0);
      check("rst_err", 32'({overflow_err, underflow_err}), 0);
      rst_n = 1'b1;
      tick();

      // Single key, gap 0: two-cycle latency, one-cycle pulse.
      put(3, 12'h1A5); expect_issue(3, 12'h1A5);
      tick(); clr_req();
      check("t1_not_yet", 32'(tag_key_valid), 0);
      tick();
      check("t1_valid", 32'(tag_key_valid), 1);
      check("t1_outstanding", 32'(outstanding), 1);
      tick();
      check("t1_pulse_end", 32'(tag_key_valid), 0);
      check("t1_ack_end", 32'(io_ack), 0);
      complete();
      check("t1_credit_back", 32'(outstanding), 0);

      // Three PUs at once, gap 2: issues exactly 3 cycles apart.
      cfg_issue_gap = 3'd2;
      base = n_issue;
      put(0, 12'h011); put(1, 12'h022); put(2, 12'h033);
      expect_issue(0, 12'h011); expect_issue(1, 12'h022); expect_issue(2, 12'h033);
      tick(); clr_req();
      tick(10);
      check("t2_count", 32'(n_issue - base), 3);
      check("t2_gap_a", 32'(issue_cyc[base+1] - issue_cyc[base]), 3);
      check("t2_gap_b", 32'(issue_cyc[base+2] - issue_cyc[base+1]), 3);
      check("t2_outstanding", 32'(outstanding), 3);
      repeat (3) complete();
      check("t2_drained", 32'(outstanding), 0);

      // Credit limit: six queued keys, only four issue until a credit returns.
      cfg_issue_gap = 3'd0;
      base = n_issue;
      for (int i = 0; i < 6; i++) put(i, 12'(12'h100 + i));
      expect_issue(3, 12'h103); expect_issue(4, 12'h104); expect_issue(5, 12'h105);
      expect_issue(0, 12'h100); expect_issue(1, 12'h101); expect_issue(2, 12'h102);
      tick(); clr_req();
      tick(8);
      check("t3_stall_count", 32'(n_issue - base), 4);
      check("t3_stall_outstanding", 32'(outstanding), 4);
      complete(); tick(3);
      check("t3_release_5th", 32'(n_issue - base), 5);
      check("t3_outstanding_5th", 32'(outstanding), 4);
      complete(); tick(3);
      check("t3_release_6th", 32'(n_issue - base), 6);
      repeat (4) complete();
      check("t3_drained", 32'(outstanding), 0);

      // Overflow: credits exhausted by PU7, then PU5 pushes five keys.
      base = n_issue;
      for (int k = 0; k < 4; k++) begin
         put(7, 12'(12'h700 + k)); expect_issue(7, 12'(12'h700 + k));
         tick();
      end
      clr_req();
      tick(3);
      check("t4_blocked", 32'(outstanding), 4);
      for (int k = 0; k < 5; k++) begin
         put(5, 12'(12'h501 + k));
         if (k < 4) expect_issue(5, 12'(12'h501 + k));
         tick();
      end
      clr_req();
      check("t4_overflow", 32'(overflow_err), 32'h20);
      check("t4_full", 32'(fifo_full), 32'h20);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("t4_err_clr", 32'(overflow_err), 0);
      check("t4_still_full", 32'(fifo_full), 32'h20);
      repeat (8) begin complete(); tick(); end
      check("t4_issued", 32'(n_issue - base), 8);
      check("t4_empty", 32'(fifo_full), 0);
      check("t4_drained", 32'(outstanding), 0);

      // Simultaneous issue and completion at outstanding 2.
      put(1, 12'h1C1); expect_issue(1, 12'h1C1); tick();
      put(1, 12'h1C2); expect_issue(1, 12'h1C2); tick();
      clr_req(); tick(3);
      check("t5_pre", 32'(outstanding), 2);
      put(1, 12'h1C3); expect_issue(1, 12'h1C3);
      tick(); clr_req();
      status_valid = 1'b1; tick(); status_valid = 1'b0;
      check("t5_simul_valid", 32'(tag_key_valid), 1);
      check("t5_simul_hold", 32'(outstanding), 2);
      repeat (2) complete();
      check("t5_zero", 32'(outstanding), 0);
      complete();
      check("t5_underflow", 32'(underflow_err), 1);
      check("t5_underflow_cnt", 32'(outstanding), 0);
      err_clr = 1'b1; status_valid = 1'b1; tick();
      err_clr = 1'b0; status_valid = 1'b0;
      check("t5_new_err_wins", 32'(underflow_err), 1);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("t5_err_clr", 32'(underflow_err), 0);

      // Reset with keys queued and credits in use discards everything.
      cfg_issue_gap = 3'd7;
      put(6, 12'h601); expect_issue(6, 12'h601); tick();
      put(6, 12'h602); expect_issue(6, 12'h602); tick();
      clr_req(); tick(10);
      check("t6_outstanding", 32'(outstanding), 2);
      for (int k = 0; k < 3; k++) begin put(3, 12'(12'h3E0 + k)); tick(); end
      clr_req();
      base = n_issue;
      rst_n = 1'b0;
      tick();
      check("t6_rst_valid", 32'(tag_key_valid), 0);
      check("t6_rst_key_pid", 32'({tag_key, tag_pid}), 0);
      check("t6_rst_outstanding", 32'(outstanding), 0);
      check("t6_rst_ack", 32'(io_ack), 0);
      rst_n = 1'b1; cfg_issue_gap = 3'd0;
      tick(10);
      check("t6_no_issue", 32'(n_issue - base), 0);
      io_req[2] = 1'b1; io_cmd[2].wr = 1'b1; io_cmd[2].addr = 16'h1000; io_cmd[2].wdata = 32'h2AA;
      tick(); clr_req(); tick(4);
      check("t6_wrong_addr", 32'(n_issue - base), 0);
      put(2, 12'h2B7); expect_issue(2, 12'h2B7);
      tick(); clr_req(); tick(3);
      check("t6_new_issue", 32'(n_issue - base), 1);
      check("t6_new_outstanding", 32'(outstanding), 1);
      check("sb_drained", 32'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pu_tag_req_arb.md
# pu_tag_req_arb

Parametrised tag-lookup request front end between the PU array and the tag lookup engine. It captures tag-lookup writes from every PU into a per-PU key FIFO and arbitrates round-robin among non-empty FIFOs. Issues are throttled by a programmable minimum issue gap and a credit limit on outstanding lookups. Each PU receives its `io_ack` when its key is issued, not when it is enqueued.

## Interface
Parameters:
- NUM_OF_PU, `NUM_OF_PU, number of requesting PUs (1..32)
- WIDTH_NBITS, `PU_WIDTH_NBITS, io_ack_data width
- KEY_NBITS, `TAG_NBITS, tag key width (≤ WIDTH_NBITS)
- FIFO_DEPTH_NBITS, 2, log2 of per-PU FIFO depth (depth 4 default)
- MAX_OUTSTANDING, 4, issued-but-uncompleted lookup limit (1..15)
- GAP_NBITS, 3, width of cfg_issue_gap

Ports:
- clk  in  1  sole clock
- `RESET_SIG`  in  1  asynchronous, active-low reset
- cfg_issue_gap  in  GAP_NBITS  idle cycles forced after each issue; quasi-static
- err_clr  in  1  clears sticky error flags
- io_req  in  NUM_OF_PU  per-PU request strobe
- io_cmd  in  io_type[NUM_OF_PU]  per-PU command (wr, addr, wdata)
- io_ack  out  NUM_OF_PU  one-cycle pulse: that PU's oldest key issued
- io_ack_data  out  WIDTH_NBITS[NUM_OF_PU]  always 0
- tag_key_valid  out  1  issue strobe to lookup engine
- tag_key  out  KEY_NBITS  issued key
- tag_pid  out  `PU_ID_NBITS  issuing PU
- tag_lookup_status_valid  in  1  one pulse per completed lookup (returns a credit)
- outstanding  out  4  current credits in use
- fifo_full  out  NUM_OF_PU  per-PU FIFO full
- overflow_err  out  NUM_OF_PU  sticky: request dropped at full FIFO
- underflow_err  out  1  sticky: completion seen with outstanding==0

## Operation
- Enqueue for PU i: io_req[i] & io_cmd[i].wr & addr[`PU_MEM_DEPTH_MSB_RANGE]==`PU_TAG_LOOKUP_REQ. Write wdata[KEY_NBITS-1:0] into FIFO i.
- Full is evaluated after a same-cycle pop. Enqueue and pop on a full FIFO are both accepted. Enqueue on a full FIFO with no pop is dropped and sets overflow_err[i].
- Issue is eligible when: any FIFO non-empty, gap_cnt==0, and outstanding<MAX_OUTSTANDING.
- On eligibility, the round-robin arbiter selects the first non-empty FIFO after the last-granted PU (wrap NUM_OF_PU-1→0). That FIFO is popped the same cycle. The pointer advances only on grant.
- Gap control: gap_cnt loads cfg_issue_gap on grant and decrements to 0. Issue rate is at most 1 per (cfg_issue_gap+1) cycles; gap 0 gives back-to-back issue.
- Credits: outstanding +1 on issue, −1 on status_valid. Simultaneous issue and completion leaves it unchanged. Completion at 0 is ignored and sets underflow_err.
- err_clr zeroes both sticky flags. A same-cycle new error wins.
- Reset: all outputs 0, FIFOs empty, rr pointer at PU NUM_OF_PU-1 (PU0 first), gap_cnt 0, outstanding 0.
- Reset mid-operation discards queued keys and credits. No ack is generated for discarded keys.

## Timing
- Grant decided combinationally in cycle T.
- tag_key_valid, tag_key, tag_pid, and io_ack[pid] are registered and all assert in T+1, for one cycle.
- Enqueue in cycle T: the entry is visible to the arbiter in T+1. Minimum request-to-issue latency is 2 cycles (tag_key_valid in T+2).
- outstanding, fifo_full, and error flags are registered and update in T+1.
- tag_key is held between issues; it is only meaningful with tag_key_valid.

## Structure
- type_package holds io_type. Add `TAG_REQ_MAX_OUTSTANDING and the default FIFO depth to defines.vh.
- Sub-module pu_tag_key_fifo: sync FIFO of KEY_NBITS × 2^FIFO_DEPTH_NBITS. Ports wr, din, rd, dout (first-word fall-through), full, empty.
- Round-robin selection is parametrised over NUM_OF_PU inside pu_tag_req_arb, replacing the fixed 20-way arbiter.

## Test plan
- PU3 writes key 0x1A5 once, gap 0: tag_key_valid 2 cycles later with key 0x1A5, pid 3. io_ack[3] in the same cycle; outstanding=1.
- PUs 0,1,2 each write in one cycle, gap 2: issues to pids 0,1,2 exactly 3 cycles apart. io_ack pulses match each issue.
- MAX_OUTSTANDING=4, 6 queued keys, no completions: exactly 4 issues, then stall. A status_valid pulse releases the 5th issue on the next eligible cycle.
- PU5 writes 5 keys back-to-back with depth 4 and issue blocked: 5th dropped, overflow_err[5]=1, fifo_full[5]=1. err_clr clears the flag; the 4 kept keys issue in order.
- Issue and status_valid in the same cycle at outstanding=2: stays 2. status_valid at 0: underflow_err=1.
- Assert reset with 3 keys queued and outstanding=2: all outputs 0 next cycle. After release, no tag_key_valid until a new request arrives.
